// File: rtl/game_flow_ctrl.sv
// Game scene sequencer: open -> play -> (clear -> play)* -> win/lose -> open, with pause
// and edge-detected keys. Every output is registered; transitions follow the registered scene.
module game_flow_ctrl #(
    parameter int NUM_LEVELS  = 3,
    parameter int LVL_W       = 2,
    parameter int HP_W        = 10,
    parameter int LIFE_W      = 2,
    parameter int CNT_W       = 16,
    parameter int CLEAR_HOLD  = 1000,
    parameter int RESULT_HOLD = 500
) (
    input  logic              clk_22,
    input  logic              rst,
    input  logic              space,
    input  logic              pause_key,
    input  logic [HP_W-1:0]   bosshp,
    input  logic [LIFE_W-1:0] life,
    output logic [2:0]        scene,
    output logic [LVL_W-1:0]  level,
    output logic              gamestart,
    output logic              frozen
);

    typedef enum logic [2:0] {
        S_OPEN  = 3'd0,
        S_PLAY  = 3'd1,
        S_WIN   = 3'd2,
        S_LOSE  = 3'd3,
        S_PAUSE = 3'd4,
        S_CLEAR = 3'd5
    } scene_e;

    localparam logic [LVL_W-1:0] LAST_LVL   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_HOLD - 1);
    localparam logic [CNT_W-1:0] RESULT_MIN = CNT_W'(RESULT_HOLD);

    logic [2:0]       scene_q, scene_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             gamestart_q, gamestart_d;
    logic             frozen_q;
    logic             space_q, pause_q;
    logic             space_rise, pause_rise;
    logic             win_sig, lose_sig, last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic is_timed(input logic [2:0] s);
        return (s == S_CLEAR) || (s == S_WIN) || (s == S_LOSE);
    endfunction

    assign space_rise = space & ~space_q;
    assign pause_rise = pause_key & ~pause_q;
    assign win_sig    = (bosshp == '0);
    assign lose_sig   = (life == '0);
    assign last       = (level_q == LAST_LVL);

    always_comb begin
        scene_d     = scene_q;
        level_d     = level_q;
        gamestart_d = 1'b0;
        case (scene_q)
            S_OPEN: begin
                if (space_rise) begin
                    scene_d     = S_PLAY;
                    level_d     = '0;
                    gamestart_d = 1'b1;
                end
            end
            S_PLAY: begin
                // Boss kill outranks a simultaneous death.
                if (win_sig && last)   scene_d = S_WIN;
                else if (win_sig)      scene_d = S_CLEAR;
                else if (lose_sig)     scene_d = S_LOSE;
                else if (pause_rise)   scene_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (pause_rise) scene_d = S_PLAY;
            end
            S_CLEAR: begin
                if (hold_q == CLEAR_LAST) begin
                    scene_d     = S_PLAY;
                    level_d     = level_q + LVL_W'(1);
                    gamestart_d = 1'b1;
                end
            end
            S_WIN, S_LOSE: begin
                if (space_rise && (hold_q >= RESULT_MIN)) begin
                    scene_d = S_OPEN;
                    level_d = '0;
                end
            end
            default: scene_d = S_OPEN;
        endcase

        hold_d = hold_q;
        if (is_timed(scene_d) && (scene_d != scene_q)) hold_d = '0;
        else if (is_timed(scene_q))                    hold_d = sat_inc(hold_q);
    end

    // Keys reset high so a key held through reset cannot produce an edge.
    always_ff @(posedge clk_22) begin
        if (rst) begin
            scene_q     <= S_OPEN;
            level_q     <= '0;
            hold_q      <= '0;
            gamestart_q <= 1'b0;
            frozen_q    <= 1'b0;
            space_q     <= 1'b1;
            pause_q     <= 1'b1;
        end else begin
            scene_q     <= scene_d;
            level_q     <= level_d;
            hold_q      <= hold_d;
            gamestart_q <= gamestart_d;
            frozen_q    <= (scene_d == S_PAUSE);
            space_q     <= space;
            pause_q     <= pause_key;
        end
    end

    assign scene     = scene_q;
    assign level     = level_q;
    assign gamestart = gamestart_q;
    assign frozen    = frozen_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenario tasks plus a randomized run checked
// against a scene-level reference model.
module tb_game_flow_ctrl;

    localparam int NL = 2;
    localparam int CH = 4;
    localparam int RH = 3;

    logic       clk_22 = 1'b0;
    logic       rst = 1'b1;
    logic       space = 1'b1;
    logic       pause_key = 1'b0;
    logic [9:0] bosshp = 10'd5;
    logic [1:0] life = 2'd3;
    logic [2:0] scene;
    logic [1:0] level;
    logic       gamestart;
    logic       frozen;

    int total = 0;
    int bad = 0;

    // Reference model state: age counts cycles spent in the current scene.
    int m_scene = 0, m_level = 0, m_age = 0;
    bit m_gs = 0, m_sp_prev = 1, m_pa_prev = 1;

    game_flow_ctrl #(
        .NUM_LEVELS(NL), .LVL_W(2), .HP_W(10), .LIFE_W(2), .CNT_W(16),
        .CLEAR_HOLD(CH), .RESULT_HOLD(RH)
    ) dut (
        .clk_22(clk_22), .rst(rst), .space(space), .pause_key(pause_key),
        .bosshp(bosshp), .life(life), .scene(scene), .level(level),
        .gamestart(gamestart), .frozen(frozen)
    );

    always #5 clk_22 = ~clk_22;

    task automatic model_step();
        bit sr, pr, win, lose, last;
        int ns, nl;
        bit ngs;
        if (rst) begin
            m_scene = 0; m_level = 0; m_gs = 0; m_age = 0;
            m_sp_prev = 1; m_pa_prev = 1;
            return;
        end
        sr = space && !m_sp_prev;
        pr = pause_key && !m_pa_prev;
        win = (bosshp == 0);
        lose = (life == 0);
        last = (m_level == NL - 1);
        ns = m_scene; nl = m_level; ngs = 0;
        case (m_scene)
            0: if (sr) begin ns = 1; nl = 0; ngs = 1; end
            1: begin
                if (win) ns = last ? 2 : 5;
                else if (lose) ns = 3;
                else if (pr) ns = 4;
            end
            4: if (pr) ns = 1;
            5: if (m_age == CH - 1) begin ns = 1; nl = m_level + 1; ngs = 1; end
            2, 3: if (sr && m_age >= RH) begin ns = 0; nl = 0; end
            default: ns = 0;
        endcase
        m_age = (ns != m_scene) ? 0 : m_age + 1;
        m_scene = ns; m_level = nl; m_gs = ngs;
        m_sp_prev = space; m_pa_prev = pause_key;
    endtask

    task automatic tick();
        @(posedge clk_22);
        model_step();
        @(negedge clk_22);
    endtask

    task automatic go_play();
        rst = 1; space = 0; pause_key = 0; bosshp = 5; life = 3;
        tick();
        rst = 0;
        tick();
        space = 1;
        tick();
        space = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1; space = 1; pause_key = 0; bosshp = 5; life = 3;
        tick(); tick();
        total++; if (scene !== 3'd0) begin bad++; $display("FAIL reset_scene got=%0d want=0", scene); end
        total++; if (level !== 2'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (gamestart !== 1'b0) begin bad++; $display("FAIL reset_gamestart got=%0b want=0", gamestart); end
        total++; if (frozen !== 1'b0) begin bad++; $display("FAIL reset_frozen got=%0b want=0", frozen); end
        total++; if (dut.hold_q !== 16'd0) begin bad++; $display("FAIL reset_hold got=%0d want=0", dut.hold_q); end
        rst = 0;
        tick(); tick(); tick();
        total++; if (scene !== 3'd0) begin bad++; $display("FAIL held_space_no_start got=%0d want=0", scene); end
        space = 0; tick();
        space = 1; tick();
        total++; if (scene !== 3'd1) begin bad++; $display("FAIL start_scene got=%0d want=1", scene); end
        total++; if (gamestart !== 1'b1) begin bad++; $display("FAIL start_pulse got=%0b want=1", gamestart); end
        total++; if (level !== 2'd0) begin bad++; $display("FAIL start_level got=%0d want=0", level); end
        tick();
        total++; if (gamestart !== 1'b0) begin bad++; $display("FAIL start_pulse_width got=%0b want=0", gamestart); end
        space = 0;
    endtask

    task automatic test_clear_progress();
        int n;
        go_play();
        bosshp = 0; tick(); bosshp = 5;
        n = 0;
        while (scene == 3'd5 && n < 10) begin n++; tick(); end
        total++; if (n != CH) begin bad++; $display("FAIL clear_length got=%0d want=%0d", n, CH); end
        total++; if (scene !== 3'd1) begin bad++; $display("FAIL clear_to_play got=%0d want=1", scene); end
        total++; if (level !== 2'd1) begin bad++; $display("FAIL clear_level got=%0d want=1", level); end
        total++; if (gamestart !== 1'b1) begin bad++; $display("FAIL clear_pulse got=%0b want=1", gamestart); end
        tick();
        total++; if (gamestart !== 1'b0) begin bad++; $display("FAIL clear_pulse_width got=%0b want=0", gamestart); end
        bosshp = 0; tick(); bosshp = 5;
        total++; if (scene !== 3'd2) begin bad++; $display("FAIL last_level_win got=%0d want=2", scene); end
    endtask

    task automatic test_win_priority();
        go_play();
        bosshp = 0; life = 0; tick(); bosshp = 5; life = 3;
        total++; if (scene !== 3'd5) begin bad++; $display("FAIL win_over_lose_l0 got=%0d want=5", scene); end
        repeat (CH) tick();
        total++; if (level !== 2'd1) begin bad++; $display("FAIL prio_level got=%0d want=1", level); end
        tick();
        bosshp = 0; life = 0; tick(); bosshp = 5; life = 3;
        total++; if (scene !== 3'd2) begin bad++; $display("FAIL win_over_lose_l1 got=%0d want=2", scene); end
    endtask

    task automatic test_pause();
        go_play();
        pause_key = 1; tick(); pause_key = 0;
        total++; if (scene !== 3'd4) begin bad++; $display("FAIL pause_enter got=%0d want=4", scene); end
        total++; if (frozen !== 1'b1) begin bad++; $display("FAIL pause_frozen got=%0b want=1", frozen); end
        tick();
        space = 1; bosshp = 0; life = 0;
        tick(); tick(); tick();
        total++; if (scene !== 3'd4) begin bad++; $display("FAIL pause_ignores_inputs got=%0d want=4", scene); end
        space = 0; bosshp = 5; life = 3;
        tick();
        pause_key = 1; tick(); pause_key = 0;
        total++; if (scene !== 3'd1) begin bad++; $display("FAIL pause_exit got=%0d want=1", scene); end
        total++; if (frozen !== 1'b0) begin bad++; $display("FAIL unpause_frozen got=%0b want=0", frozen); end
        total++; if (gamestart !== 1'b0) begin bad++; $display("FAIL unpause_no_pulse got=%0b want=0", gamestart); end
        tick();
        total++; if (gamestart !== 1'b0) begin bad++; $display("FAIL unpause_no_pulse2 got=%0b want=0", gamestart); end
    endtask

    task automatic test_lose_hold();
        go_play();
        bosshp = 0; tick(); bosshp = 5;
        repeat (CH) tick();
        tick();
        life = 0; tick();
        total++; if (scene !== 3'd3) begin bad++; $display("FAIL lose_enter got=%0d want=3", scene); end
        space = 1; tick();
        total++; if (scene !== 3'd3) begin bad++; $display("FAIL lose_space_cnt0 got=%0d want=3", scene); end
        space = 0; tick();
        space = 1; tick();
        total++; if (scene !== 3'd3) begin bad++; $display("FAIL lose_space_cnt2 got=%0d want=3", scene); end
        tick(); tick(); tick(); tick();
        total++; if (scene !== 3'd3) begin bad++; $display("FAIL lose_held_space got=%0d want=3", scene); end
        space = 0; tick();
        space = 1; tick();
        total++; if (scene !== 3'd0) begin bad++; $display("FAIL lose_accept got=%0d want=0", scene); end
        total++; if (level !== 2'd0) begin bad++; $display("FAIL lose_level_clear got=%0d want=0", level); end
        tick();
        total++; if (scene !== 3'd0) begin bad++; $display("FAIL lose_no_retrigger got=%0d want=0", scene); end
        space = 0; life = 3;
    endtask

    task automatic test_random();
        int shown = 0;
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 1500; i++) begin
            space     = ($urandom_range(0, 2) == 0);
            pause_key = ($urandom_range(0, 6) == 0);
            bosshp    = ($urandom_range(0, 11) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            life      = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            rst       = ($urandom_range(0, 299) == 0);
            tick();
            total++;
            if ({scene, level, gamestart, frozen} !==
                {3'(m_scene), 2'(m_level), m_gs, (m_scene == 4)}) begin
                bad++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle%0d got scene=%0d level=%0d gs=%0b frz=%0b want scene=%0d level=%0d gs=%0b frz=%0b",
                             i, scene, level, gamestart, frozen, m_scene, m_level, m_gs, (m_scene == 4));
                end
            end
        end
        rst = 0; space = 0; pause_key = 0; bosshp = 5; life = 3;
    endtask

    task automatic test_illegal();
        go_play();
        force dut.scene_q = 3'd6;
        @(posedge clk_22);
        #1 release dut.scene_q;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_22);
            if (scene == 3'd0) break;
        end
        total++; if (scene !== 3'd0) begin bad++; $display("FAIL illegal_to_open got=%0d want=0", scene); end
    endtask

    task automatic test_reset_mid_clear();
        go_play();
        bosshp = 0; tick(); bosshp = 5;
        tick(); tick(); tick();
        total++; if (scene !== 3'd5) begin bad++; $display("FAIL mid_clear_setup got=%0d want=5", scene); end
        rst = 1; tick();
        total++; if (scene !== 3'd0) begin bad++; $display("FAIL rst_mid_clear_scene got=%0d want=0", scene); end
        total++; if (level !== 2'd0) begin bad++; $display("FAIL rst_mid_clear_level got=%0d want=0", level); end
        total++; if (gamestart !== 1'b0) begin bad++; $display("FAIL rst_drops_pulse got=%0b want=0", gamestart); end
        rst = 0;
        tick();
    endtask

    initial begin
        @(negedge clk_22);
        test_reset();
        test_clear_progress();
        test_win_priority();
        test_pause();
        test_lose_hold();
        test_random();
        test_illegal();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Parametrised top-level game scene sequencer. Generalises the open/game/win/lose flow with multi-level progression, pause, level-clear interstitial, edge-detected keys and timed result screens.
- Sits between the keyboard decoder, the boss/player status logic and the VGA scene mux.
- Drives the scene code, current level index and a one-cycle level-start pulse.

Parameters:
- NUM_LEVELS, 3, number of boss levels; legal range 1..2**LVL_W.
- LVL_W, 2, width of the level output.
- HP_W, 10, width of bosshp.
- LIFE_W, 2, width of life.
- CNT_W, 16, width of the internal hold counter.
- CLEAR_HOLD, 1000, cycles spent in CLEAR before auto-advance; must be ≥1 and < 2**CNT_W.
- RESULT_HOLD, 500, cycles in WIN/LOSE during which space is ignored; must be < 2**CNT_W.

Ports:
- clk_22 in 1: system game clock.
- rst in 1: synchronous, active-high reset.
- space in 1: space key level, from the keyboard decoder.
- pause_key in 1: pause key level.
- bosshp in HP_W: current boss HP; 0 means the boss is defeated.
- life in LIFE_W: player lives remaining; 0 means dead.
- scene out 3: current scene code.
- level out LVL_W: current level index, 0-based.
- gamestart out 1: one-cycle pulse; tells game logic to (re)load HP and positions.
- frozen out 1: high while in PAUSE; game logic holds its state.

Behaviour:
- Scene encoding: OPEN=0, PLAY=1, WIN=2, LOSE=3, PAUSE=4, CLEAR=5. Codes 6 and 7 are illegal and go to OPEN on the next clock.
- All outputs are registered. Reset values: scene=OPEN, level=0, gamestart=0, frozen=0, hold counter=0.
- Edge detect: space_q and pause_q are registered copies of the inputs; both reset to 1, so a key held through reset does not fire.
  - space_rise = space & ~space_q.
  - pause_rise = pause_key & ~pause_q.
- win_sig = (bosshp == 0). lose_sig = (life == 0). last = (level == NUM_LEVELS-1).
- Hold counter:
  - Cleared to 0 on the cycle scene enters CLEAR, WIN or LOSE.
  - Otherwise increments each cycle while in those states, saturating at all-ones.
- Transitions are evaluated on registered scene; the new scene appears one clk_22 after the qualifying input cycle.
  - OPEN: space_rise -> PLAY. Same edge: level<=0, gamestart<=1.
  - PLAY, priority highest first:
    - win_sig & last -> WIN.
    - win_sig & ~last -> CLEAR.
    - lose_sig -> LOSE.
    - pause_rise -> PAUSE.
    - Otherwise stay.
    - win_sig has priority over a simultaneous lose_sig.
  - PAUSE: pause_rise -> PLAY, with no gamestart pulse. space is ignored. win_sig/lose_sig are not evaluated.
  - CLEAR: when counter == CLEAR_HOLD-1 -> PLAY. Same edge: level<=level+1, gamestart<=1. CLEAR therefore lasts exactly CLEAR_HOLD cycles.
  - WIN/LOSE:
    - space_rise is accepted only when counter ≥ RESULT_HOLD; then -> OPEN with level<=0.
    - With RESULT_HOLD=0, space_rise is accepted from the first cycle.
- gamestart is high only in the single cycle where scene first reads PLAY after OPEN or CLEAR. It is 0 in all other cycles, including PAUSE->PLAY.
- frozen equals (scene==PAUSE), registered together with scene.
- level changes only on CLEAR->PLAY (increment) and on OPEN->PLAY or WIN/LOSE->OPEN (clear to 0). It never exceeds NUM_LEVELS-1.
- Reset mid-operation overrides everything. A gamestart pulse in flight is dropped.
- NUM_LEVELS=1: first boss kill goes straight to WIN; CLEAR is unreachable.

Test Plan:
- Use NUM_LEVELS=2, CLEAR_HOLD=4, RESULT_HOLD=3, bosshp=5, life=3 unless stated.
- Reset with space held high, then keep space high -> scene stays 0. Release space, then press -> scene=1 on the next cycle, gamestart=1 for exactly 1 cycle, level=0.
- In PLAY, drive bosshp=0 for 1 cycle:
  - Expect scene=5 for exactly 4 cycles, then scene=1, level=1, gamestart pulse.
  - Drive bosshp=0 again -> scene=2.
- In PLAY, drive bosshp=0 and life=0 in the same cycle at level 0 -> scene=5, not 3. Repeat at level 1 -> scene=2.
- In PLAY, pulse pause_key -> scene=4, frozen=1.
  - Apply space, bosshp=0 and life=0 -> scene stays 4.
  - Pulse pause_key -> scene=1, frozen=0, gamestart stays 0.
- In LOSE (life=0):
  - space_rise at counter 0..2 -> ignored.
  - space_rise at counter ≥3 -> scene=0, level=0.
  - Holding space continuously does not retrigger.
- Force an illegal scene code 6 (bench force) -> scene=0 next cycle. Assert rst mid-CLEAR -> scene=0, level=0, gamestart=0 next cycle.
